// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer: FSM state encodings and
// per-board settle windows (30 ms at the listed clock).
package debounce_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam int DELAY_50MHZ  = 1500000;
  localparam int DELAY_100MHZ = 3000000;

endpackage

// File: rtl/debounce_rr_pick.sv
// Round-robin picker: first pending channel at or after ptr, wrapping
// from N_CH-1 back to 0.
module debounce_rr_pick #(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  int idx_s;

  // scan from ptr; the first hit wins and later hits are ignored
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx_s = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx_s = (int'(ptr) + i) % N_CH;
      if (!valid && pending[idx_s]) begin
        valid = 1'b1;
        grant = IDX_W'(idx_s);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N_CH switches with one shared settle counter granted round-robin
// to channels whose synchronized level differs from their stable level.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DELAY_CYCLES = DELAY_50MHZ,
  parameter int CNT_W        = 21,
  parameter int GID_W        = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sw,
  output logic [N_CH-1:0]  stable,
  output logic [N_CH-1:0]  one_shot,
  output logic             busy,
  output logic [GID_W-1:0] grant_id
);

  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync_r;
  logic [N_CH-1:0]  pending_s;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [GID_W-1:0] ptr_r;
  logic [GID_W-1:0] pick_grant_s;
  logic             pick_valid_s;
  logic             cnt_done_s;

  function automatic logic [GID_W-1:0] next_idx(input logic [GID_W-1:0] g);
    if (g == GID_W'(N_CH - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = g + GID_W'(1);
    end
  endfunction

  assign pending_s  = sync_r ^ stable;
  assign cnt_done_s = (cnt_r == CNT_W'(DELAY_CYCLES - 1));

  debounce_rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (GID_W)
  ) u_pick (
    .pending (pending_s),
    .ptr     (ptr_r),
    .grant   (pick_grant_s),
    .valid   (pick_valid_s)
  );

  // two-flop synchronizer for the raw asynchronous switch levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync_r  <= '0;
    end else begin
      sync1_r <= sw;
      sync_r  <= sync1_r;
    end
  end

  // grant / settle / commit sequencer; one_shot defaults low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      ptr_r    <= '0;
      grant_id <= '0;
      stable   <= '0;
      one_shot <= '0;
      busy     <= 1'b0;
    end else begin
      one_shot <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_id <= pick_grant_s;
            cnt_r    <= '0;
            state_r  <= ST_WAIT;
            busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          // saturate so the counter cannot wrap when CNT_W is tight
          if (!cnt_done_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          if (sync_r[grant_id] == stable[grant_id]) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            ptr_r   <= next_idx(grant_id);
          end else if (cnt_done_s) begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sync_r[grant_id] != stable[grant_id]) begin
            stable[grant_id]   <= sync_r[grant_id];
            one_shot[grant_id] <= sync_r[grant_id];
          end
          ptr_r   <= next_idx(grant_id);
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler (N_CH=4, DELAY_CYCLES=8): stimulus
// pushes expected stable/one_shot events, a negedge monitor pops and compares.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b1111;
  logic [3:0] stable;
  logic [3:0] one_shot;
  logic       busy;
  logic [1:0] grant_id;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int s;
  int r;

  typedef struct {
    int         cyc;
    logic [3:0] os;
    logic [3:0] st;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] prev_st = 4'b0000;

  debounce_scheduler #(
    .N_CH         (4),
    .DELAY_CYCLES (8),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .stable   (stable),
    .one_shot (one_shot),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] os, input logic [3:0] st);
    exp_t e;
    e.cyc = c;
    e.os  = os;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor: any one_shot pulse or stable change is an output event
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_st <= stable;
    end else begin
      if (one_shot != 4'b0000 || stable != prev_st) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: one_shot=%b stable=%b, expected no event (cycle %0d)",
                   one_shot, stable, cyc);
        end else begin
          e = exp_q.pop_front();
          check("evt_cycle", cyc, e.cyc);
          check("evt_one_shot", int'(one_shot), int'(e.os));
          check("evt_stable", int'(stable), int'(e.st));
        end
      end
      prev_st <= stable;
    end
  end

  initial begin
    // 1: reset held three cycles with all switches high
    repeat (3) begin
      @(negedge clk);
      check("rst_stable", int'(stable), 0);
      check("rst_one_shot", int'(one_shot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_grant_id", int'(grant_id), 0);
    end
    sw  = 4'b0000;
    rst = 1'b0;
    step(4);
    check("idle_busy", int'(busy), 0);

    // 2: single rising switch on channel 1
    s  = cyc + 1;
    sw = 4'b0010;
    push(s + 11, 4'b0010, 4'b0010);
    to_cyc(s + 1);  check("t2_busy_e2", int'(busy), 0);
    to_cyc(s + 2);  check("t2_busy_e3", int'(busy), 1);
    to_cyc(s + 10); check("t2_busy_e11", int'(busy), 1);
                    check("t2_grant", int'(grant_id), 1);
    to_cyc(s + 11); check("t2_busy_e12", int'(busy), 0);
    step(3);

    // 3: bounce on channel 0 aborts the window
    s  = cyc + 1;
    sw = 4'b0011;
    step(3);
    sw = 4'b0010;
    to_cyc(s + 2); check("t3_busy", int'(busy), 1);
                   check("t3_grant", int'(grant_id), 0);
    to_cyc(s + 4); check("t3_busy_e5", int'(busy), 1);
    to_cyc(s + 5); check("t3_abort", int'(busy), 0);
    step(4);
    check("t3_stable", int'(stable), 2);

    // pointer left at 1 after abort: channel 2 beats channel 0
    s  = cyc + 1;
    sw = 4'b0111;
    push(s + 11, 4'b0100, 4'b0110);
    push(s + 21, 4'b0001, 4'b0111);
    to_cyc(s + 2);  check("ptr_after_abort", int'(grant_id), 2);
    to_cyc(s + 12); check("rr_next_grant", int'(grant_id), 0);
    to_cyc(s + 25);

    // 5: falling commit on channel 1, no pulse
    s  = cyc + 1;
    sw = 4'b0101;
    push(s + 11, 4'b0000, 4'b0101);
    to_cyc(s + 2);  check("t5_grant", int'(grant_id), 1);
    to_cyc(s + 10); check("t5_stable_early", int'(stable), 7);
    to_cyc(s + 14);

    rst = 1'b1;
    sw  = 4'b0000;
    step(2);
    check("rst2_stable", int'(stable), 0);
    rst = 1'b0;
    step(3);

    // 4: two channels rise together, serviced 10 cycles apart
    s  = cyc + 1;
    sw = 4'b0101;
    push(s + 11, 4'b0001, 4'b0001);
    push(s + 21, 4'b0100, 4'b0101);
    to_cyc(s + 25);

    rst = 1'b1;
    sw  = 4'b0000;
    step(2);
    rst = 1'b0;
    step(3);

    // 6: reset lands mid-WAIT, then the held press is re-debounced
    s  = cyc + 1;
    sw = 4'b1000;
    to_cyc(s + 4);
    check("t6_busy_pre", int'(busy), 1);
    rst = 1'b1;
    step(2);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_stable", int'(stable), 0);
    check("t6_rst_one_shot", int'(one_shot), 0);
    rst = 1'b0;
    r   = cyc + 1;
    push(r + 11, 4'b1000, 4'b1000);
    to_cyc(r + 14);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_event: no output event, expected one_shot=%b stable=%b at cycle %0d",
               e.os, e.st, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
